// File: rtl/button_conditioner.sv
// button_conditioner: 2-flop synchronizer plus per-button debounce FSM for the seven player
// buttons. Produces a debounced level and a one-cycle press pulse per button, and their OR.
// Optional hold-to-repeat on masked buttons is built only when BUTTON_AUTOREPEAT_EN is defined.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES     = 16,
    parameter int unsigned REPEAT_CYCLES   = 8,
    parameter logic [6:0]  REPEAT_MASK     = 7'h3C
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] btn_raw,
    output logic [6:0] btn_level,
    output logic [6:0] btn_press,
    output logic       any_press
);

    localparam int unsigned MAX_DH  = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES
                                                                      : HOLD_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_DH > REPEAT_CYCLES) ? MAX_DH : REPEAT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_CNT = CNT_W'(DEBOUNCE_CYCLES);
`ifdef BUTTON_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] REP_CNT  = CNT_W'(REPEAT_CYCLES);
`else
    // Mask only matters for the repeat build.
    logic unused_mask;
    assign unused_mask = ^REPEAT_MASK;
`endif

    typedef enum logic [1:0] {StIdle, StDebDn, StHeld, StDebUp} state_e;

    logic [6:0] sync1_q, sync2_q;

    // Two-flop synchronizer; the FSMs only ever look at sync2_q.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < 7; i++) begin : g_btn
        state_e           state_q;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_inc;
        logic             level_q;
        logic             press_q;
`ifdef BUTTON_AUTOREPEAT_EN
        // Set once the initial hold period has elapsed; cnt_q then times repeat intervals.
        logic             rep_q;
`endif

        assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

        // Debounce FSM with registered level and press outputs.
        always_ff @(posedge clk) begin
            if (!reset) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                level_q <= 1'b0;
                press_q <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
                rep_q   <= 1'b0;
`endif
            end else begin
                press_q <= 1'b0;
                case (state_q)
                    StIdle: begin
                        if (sync2_q[i]) begin
                            state_q <= StDebDn;
                            cnt_q   <= CNT_ONE;
                        end
                    end
                    StDebDn: begin
                        if (!sync2_q[i]) begin
                            state_q <= StIdle;
                            cnt_q   <= '0;
                        end else if (cnt_q == DEB_CNT) begin
                            state_q <= StHeld;
                            cnt_q   <= '0;
                            press_q <= 1'b1;
                            level_q <= 1'b1;
`ifdef BUTTON_AUTOREPEAT_EN
                            rep_q   <= 1'b0;
`endif
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    StHeld: begin
                        if (!sync2_q[i]) begin
                            state_q <= StDebUp;
                            cnt_q   <= CNT_ONE;
                        end else begin
`ifdef BUTTON_AUTOREPEAT_EN
                            if (REPEAT_MASK[i] && !rep_q && cnt_inc == HOLD_CNT) begin
                                press_q <= 1'b1;
                                rep_q   <= 1'b1;
                                cnt_q   <= '0;
                            end else if (REPEAT_MASK[i] && rep_q && cnt_inc == REP_CNT) begin
                                press_q <= 1'b1;
                                cnt_q   <= '0;
                            end else begin
                                cnt_q <= cnt_inc;
                            end
`else
                            cnt_q <= cnt_inc;
`endif
                        end
                    end
                    StDebUp: begin
                        if (sync2_q[i]) begin
                            // Bounce back: no new pulse, and the hold period starts over.
                            state_q <= StHeld;
                            cnt_q   <= '0;
`ifdef BUTTON_AUTOREPEAT_EN
                            rep_q   <= 1'b0;
`endif
                        end else if (cnt_q == DEB_CNT) begin
                            state_q <= StIdle;
                            cnt_q   <= '0;
                            level_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                    end
                endcase
            end
        end

        assign btn_level[i] = level_q;
        assign btn_press[i] = press_q;
    end

    assign any_press = |btn_press;

endmodule
